pot_scan_sequencer: RTL and testbench
=====================================

# pot_scan_sequencer

Round-robin scheduler that shares the single slide-pot A2D SPI interface among the six equalizer controls (LP, B1, B2, B3, HP, volume). It issues conversion requests on the fixed channel map, waits for completion with a timeout, and holds the latest 12-bit result for each control in a register. The equalizer filter/gain datapath reads these registers. The block sits between the A2D interface (toward the ADC128S) and the band-gain logic in the equalizer top level.

## Interface
- GAP, 256, idle cycles between a conversion completing and the next request
- TIMEOUT, 4096, max cycles waiting for cnv_cmplt before aborting a conversion
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  scan enable
- strt_cnv  out  1  one-cycle conversion request to A2D interface
- chnnl  out  3  A2D channel; stable from strt_cnv until completion or abort
- cnv_cmplt  in  1  one-cycle completion pulse from A2D interface
- res  in  12  conversion result; valid when cnv_cmplt=1
- pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, pot_vol  out  12 each  latest value per control
- scan_done  out  1  one-cycle pulse after the slot-5 (volume) update or abort
- timeout_err  out  1  sticky; set on any abort, cleared only by rst

## Operation
- Slot order and channel map: slot0 LP=ch1, slot1 B1=ch0, slot2 B2=ch4, slot3 B3=ch2, slot4 HP=ch3, slot5 VOL=ch7. After slot5 the index wraps to slot0.
- States:
  - IDLE: stay while en=0; go to START when en=1.
  - START: strt_cnv=1 for exactly one cycle, chnnl=map[idx], timer cleared; next state WAIT.
  - WAIT:
    - cnv_cmplt=1 → write res to slot idx, go to GAP.
    - Timer reaches TIMEOUT-1 first → set timeout_err, slot unchanged, go to GAP.
    - If cnv_cmplt and timeout coincide, completion wins; no error.
  - GAP: count GAP cycles; on the last cycle advance idx, pulse scan_done if idx was 5, then go to START if en=1, else IDLE.
- en deasserted mid-conversion: the current WAIT/GAP completes normally, then IDLE. idx is retained; scan resumes at the next slot.
- cnv_cmplt outside WAIT is ignored.
- Reset values: every pot_* = 12'h000, strt_cnv=0, chnnl=3'd1, scan_done=0, timeout_err=0, idx=0, state IDLE. Reset mid-conversion aborts it with no write.

## Timing
- en sampled high in IDLE → strt_cnv high on the next cycle.
- cnv_cmplt high in cycle N → pot register updated at edge N+1 (visible in cycle N+1).
- Request-to-request spacing = 1 (START) + WAIT cycles + GAP cycles.
- Abort: strt_cnv in cycle S → timeout_err visible in cycle S+TIMEOUT+1.
- scan_done is asserted in the cycle after the last GAP cycle of slot5, concurrent with the next START.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- POT_FILTER_EN defined:
  - Each slot has a first-sample flag, cleared by rst.
  - First write loads res directly.
  - Later writes store old + ((res − old) >>> 2), using 13-bit signed difference and arithmetic shift, truncated to 12 bits. The result never exceeds the range [min(old,res), max(old,res)].
- POT_FILTER_EN undefined: res is stored directly; no flags and no filter logic.

## Structure
- Shared package eq_pkg holds:
  - state enum (IDLE, START, WAIT, GAP)
  - slot index type (3 bits)
  - channel-map constant array
  - default GAP and TIMEOUT constants
- Sub-module pot_smooth (one-slot filter update) exists only under POT_FILTER_EN. The rest is a single flat module.

## Test plan
- Reset, then en=1, model responds after 40 cycles with res=12'hABC → strt_cnv with chnnl=1, then pot_lp=12'hABC one cycle after cnv_cmplt.
- en held high over 12 conversions → chnnl sequence 1,0,4,2,3,7,1,0,4,2,3,7; exactly two scan_done pulses; request spacing = 1 + model latency + GAP.
- Model never asserts cnv_cmplt on ch4 → timeout_err=1 TIMEOUT+1 cycles after the request; pot_b2 unchanged; next request on ch2.
- en dropped during WAIT on ch0 → completion stored to pot_b1, then IDLE; en re-raised → next request on ch4.
- rst asserted in WAIT → all outputs at reset values next cycle; a late cnv_cmplt is ignored.
- POT_FILTER_EN: pot_hp first sample 12'h400, then 12'h800 → 12'h400, then 12'h500.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and constants for the slide-pot scan sequencer.
// Slot order, channel map and default timing live here.
package eq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP
  } state_t;

  typedef logic [2:0] slot_t;
  typedef logic [2:0] chan_t;
  typedef logic [11:0] pot_t;

  localparam int NSLOT = 6;
  localparam slot_t LAST_SLOT = 3'd5;

  // Slot order LP, B1, B2, B3, HP, VOL
  localparam chan_t CHMAP [NSLOT] = '{
    3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7
  };

  localparam int DEF_GAP = 256;
  localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/pot_scan_sequencer_if.sv
// Request/complete handshake between the scan sequencer
// (master) and the A2D SPI interface (slave).
interface pot_scan_sequencer_if;
  import eq_pkg::*;

  logic  strt_cnv;
  chan_t chnnl;
  logic  cnv_cmplt;
  pot_t  res;

  modport master (
    output strt_cnv,
    output chnnl,
    input  cnv_cmplt,
    input  res
  );

  modport slave (
    input  strt_cnv,
    input  chnnl,
    output cnv_cmplt,
    output res
  );

endinterface

// File: rtl/pot_smooth.sv
// One-slot smoothing update: first sample loads directly, later
// samples move a quarter of the way toward the new reading.
`ifdef POT_FILTER_EN
module pot_smooth
  import eq_pkg::*;
(
  input  logic first,
  input  pot_t old,
  input  pot_t sample,
  output pot_t upd
);

  logic signed [12:0] diff;

  assign diff = $signed({1'b0, sample})
              - $signed({1'b0, old});

  // Floor shift keeps the result between old and sample
  assign upd = first ? sample
                     : old + 12'(diff >>> 2);

endmodule
`endif

// File: rtl/pot_scan_sequencer.sv
// Round-robin A2D scheduler for the six equalizer pots.
// Define POT_FILTER_EN to smooth each slot via pot_smooth.
module pot_scan_sequencer
  import eq_pkg::*;
#(
  parameter int GAP = DEF_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  pot_scan_sequencer_if.master a2d,
  output pot_t pot_lp,
  output pot_t pot_b1,
  output pot_t pot_b2,
  output pot_t pot_b3,
  output pot_t pot_hp,
  output pot_t pot_vol,
  output logic scan_done,
  output logic timeout_err
);

  localparam int CW =
    $clog2((GAP > TIMEOUT) ? GAP : TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

  state_t        state;
  slot_t         idx;
  slot_t         nidx;
  logic [CW-1:0] timer;
  pot_t          pot [NSLOT];
  pot_t          nxt;

  assign nidx = (idx == LAST_SLOT) ? '0 : idx + 3'd1;

`ifdef POT_FILTER_EN
  logic [NSLOT-1:0] seen;

  pot_smooth u_smooth (
    .first  (!seen[idx]),
    .old    (pot[idx]),
    .sample (a2d.res),
    .upd    (nxt)
  );
`else
  assign nxt = a2d.res;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      idx             <= '0;
      timer           <= '0;
      a2d.strt_cnv    <= 1'b0;
      a2d.chnnl       <= 3'd1;
      scan_done       <= 1'b0;
      timeout_err     <= 1'b0;
      pot             <= '{default: '0};
`ifdef POT_FILTER_EN
      seen            <= '0;
`endif
    end else begin
      a2d.strt_cnv <= 1'b0;
      scan_done    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (en) begin
            state        <= ST_START;
            a2d.strt_cnv <= 1'b1;
            a2d.chnnl    <= CHMAP[idx];
          end
        end
        ST_START: begin
          state <= ST_WAIT;
          timer <= '0;
        end
        ST_WAIT: begin
          timer <= timer + CW'(1);
          // Completion beats a same-cycle timeout
          if (a2d.cnv_cmplt) begin
            pot[idx] <= nxt;
`ifdef POT_FILTER_EN
            seen[idx] <= 1'b1;
`endif
            state <= ST_GAP;
            timer <= '0;
          end else if (timer == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_GAP;
            timer       <= '0;
          end
        end
        ST_GAP: begin
          timer <= timer + CW'(1);
          if (timer == GAP_LAST) begin
            idx       <= nidx;
            scan_done <= (idx == LAST_SLOT);
            timer     <= '0;
            if (en) begin
              state        <= ST_START;
              a2d.strt_cnv <= 1'b1;
              a2d.chnnl    <= CHMAP[nidx];
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pot_lp  = pot[0];
  assign pot_b1  = pot[1];
  assign pot_b2  = pot[2];
  assign pot_b3  = pot[3];
  assign pot_hp  = pot[4];
  assign pot_vol = pot[5];

endmodule

// File: tb/tb_pot_scan_sequencer.sv
// Scoreboard bench for pot_scan_sequencer: a random A2D responder
// feeds a slot-level reference model; a monitor checks the DUT.
module tb_pot_scan_sequencer;

  localparam int GAP = 256;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [11:0] pot_lp, pot_b1, pot_b2;
  logic [11:0] pot_b3, pot_hp, pot_vol;
  logic scan_done, timeout_err;

  always #5 clk = ~clk;

  pot_scan_sequencer_if a2d ();

  pot_scan_sequencer #(
    .GAP(GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .a2d(a2d),
    .pot_lp(pot_lp),
    .pot_b1(pot_b1),
    .pot_b2(pot_b2),
    .pot_b3(pot_b3),
    .pot_hp(pot_hp),
    .pot_vol(pot_vol),
    .scan_done(scan_done),
    .timeout_err(timeout_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: slot order LP,B1,B2,B3,HP,VOL
  int chan_tab [6] = '{1, 0, 4, 2, 3, 7};
  logic [11:0] ref_pot [6];
  int ref_idx;
  bit ref_err;
`ifdef POT_FILTER_EN
  bit ref_seen [6];
`endif

  typedef struct { int cyc; int ch; } req_t;
  typedef struct { int cyc; int slot; logic [11:0] val; } potchk_t;
  typedef struct { int lat; logic [11:0] val; } plan_t;

  req_t    exp_req [$];
  int      exp_done [$];
  potchk_t exp_pot [$];
  int      exp_err [$];
  plan_t   plan_q [$];

  int drop_ch = -1;
  bit rst_test = 1'b0;
  int nreq = 0;
  int ncmpl = 0;
  int ndone = 0;
  int cur_ch = -1;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      ref_pot[i] = '0;
`ifdef POT_FILTER_EN
      ref_seen[i] = 1'b0;
`endif
    end
    ref_idx = 0;
    ref_err = 1'b0;
  endtask

  // Conversion of the current slot ends in cycle c
  task automatic model_finish(input int c, input bit ok,
                              input logic [11:0] v);
    int s;
    potchk_t pk;
    req_t r;
`ifdef POT_FILTER_EN
    int d;
`endif
    s = ref_idx;
    if (ok) begin
`ifdef POT_FILTER_EN
      if (!ref_seen[s]) ref_pot[s] = v;
      else begin
        d = int'(v) - int'(ref_pot[s]);
        ref_pot[s] = 12'(int'(ref_pot[s]) + (d >>> 2));
      end
      ref_seen[s] = 1'b1;
`else
      ref_pot[s] = v;
`endif
    end else begin
      ref_err = 1'b1;
      exp_err.push_back(c + 1);
    end
    pk.cyc = c + 1;
    pk.slot = s;
    pk.val = ref_pot[s];
    exp_pot.push_back(pk);
    ref_idx = (s + 1) % 6;
    if (s == 5) exp_done.push_back(c + GAP + 1);
    if (en) begin
      r.cyc = c + GAP + 1;
      r.ch = chan_tab[ref_idx];
      exp_req.push_back(r);
    end
  endtask

  function automatic logic [11:0] pot_of(input int s);
    case (s)
      0: return pot_lp;
      1: return pot_b1;
      2: return pot_b2;
      3: return pot_b3;
      4: return pot_hp;
      default: return pot_vol;
    endcase
  endfunction

  // A2D responder: random latency/value unless a plan entry exists
  initial begin
    int s0, lat;
    logic [11:0] v;
    bit drop;
    plan_t p;
    a2d.cnv_cmplt = 1'b0;
    a2d.res = '0;
    forever begin
      @(negedge clk);
      if (a2d.strt_cnv === 1'b1) begin
        s0 = cyc;
        nreq++;
        cur_ch = chan_tab[ref_idx];
        if (plan_q.size() > 0) begin
          p = plan_q.pop_front();
          lat = p.lat;
          v = p.val;
        end else begin
          lat = $urandom_range(50, 4);
          v = 12'($urandom);
        end
        drop = (cur_ch == drop_ch) && !rst_test;
        if (drop) lat = TIMEOUT;
        while (cyc < s0 + lat) begin
          @(posedge clk);
          #1;
        end
        if (!drop) begin
          a2d.res = v;
          a2d.cnv_cmplt = 1'b1;
        end
        if (!rst_test) model_finish(cyc, !drop, v);
        ncmpl++;
        if (!drop) begin
          @(posedge clk);
          #1;
          a2d.cnv_cmplt = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations as the DUT presents events
  initial begin
    req_t r;
    potchk_t pk;
    int dc;
    forever begin
      @(negedge clk);
      if (a2d.strt_cnv === 1'b1) begin
        if (exp_req.size() == 0)
          chk("unexpected_request", 32'(a2d.strt_cnv), 0);
        else begin
          r = exp_req.pop_front();
          chk("request_cycle", cyc, r.cyc);
          chk("request_chnnl", 32'(a2d.chnnl), r.ch);
        end
      end else if (exp_req.size() > 0 && exp_req[0].cyc < cyc) begin
        r = exp_req.pop_front();
        chk("missing_request", cyc, r.cyc);
      end
      if (scan_done === 1'b1) begin
        ndone++;
        if (exp_done.size() == 0)
          chk("unexpected_scan_done", 32'(scan_done), 0);
        else begin
          dc = exp_done.pop_front();
          chk("scan_done_cycle", cyc, dc);
        end
      end else if (exp_done.size() > 0 && exp_done[0] < cyc) begin
        dc = exp_done.pop_front();
        chk("missing_scan_done", cyc, dc);
      end
      while (exp_pot.size() > 0 && exp_pot[0].cyc <= cyc) begin
        pk = exp_pot.pop_front();
        chk($sformatf("pot_slot%0d", pk.slot),
            32'(pot_of(pk.slot)), 32'(pk.val));
      end
      if (exp_err.size() > 0 && exp_err[0] <= cyc) begin
        dc = exp_err.pop_front();
        chk("timeout_err_set", 32'(timeout_err), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_nreq(input int target, input int budget);
    int b;
    b = budget;
    while (nreq < target && b > 0) begin tick(); b--; end
    chk("request_count_reached", 32'(nreq >= target), 1);
  endtask

  task automatic wait_ncmpl(input int target, input int budget);
    int b;
    b = budget;
    while (ncmpl < target && b > 0) begin tick(); b--; end
    chk("completion_count_reached", 32'(ncmpl >= target), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_pot%0d", tag, i), 32'(pot_of(i)), 0);
    chk({tag, "_strt_cnv"}, 32'(a2d.strt_cnv), 0);
    chk({tag, "_chnnl"}, 32'(a2d.chnnl), 1);
    chk({tag, "_scan_done"}, 32'(scan_done), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  task automatic raise_en();
    req_t r;
    en = 1'b1;
    r.cyc = cyc + 1;
    r.ch = chan_tab[ref_idx];
    exp_req.push_back(r);
  endtask

  initial begin
    plan_t p;
    int n0, nc0, b;
    rst = 1'b1;
    en = 1'b0;
    model_reset();
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // First LP sample 0xABC after 40 cycles, then a
    // completion landing exactly on the timeout cycle
    p.lat = 40; p.val = 12'hABC; plan_q.push_back(p);
    p.lat = TIMEOUT; p.val = 12'($urandom); plan_q.push_back(p);
    raise_en();
    wait_nreq(13, 13 * (GAP + 60) + TIMEOUT + 200);
    chk("scan_done_pulses", ndone, 2);
    chk("no_timeout_on_coincidence", 32'(timeout_err), 0);

    // B2 (ch4) never answers
    drop_ch = 4;
    b = 3 * (GAP + 60) + TIMEOUT + 200;
    while (!ref_err && b > 0) begin tick(); b--; end
    chk("abort_reached", 32'(ref_err), 1);
    drop_ch = -1;
    wait_nreq(nreq + 1, GAP + 100);

    // Drop en while B1 (ch0) is in flight
    n0 = nreq;
    b = 8 * (GAP + 60);
    while (!(nreq != n0 && cur_ch == 0) && b > 0) begin
      tick(); b--;
    end
    chk("b1_request_seen", cur_ch, 0);
    nc0 = ncmpl;
    en = 1'b0;
    wait_ncmpl(nc0 + 1, 100);
    repeat (GAP + 10) tick();
    chk("timeout_err_sticky", 32'(timeout_err), 32'(ref_err));
    raise_en();

    // Reset in the middle of the following conversion
    nc0 = ncmpl;
    wait_ncmpl(nc0 + 1, 100);
    p.lat = 20; p.val = 12'($urandom); plan_q.push_back(p);
    rst_test = 1'b1;
    wait_nreq(nreq + 1, GAP + 100);
    repeat (4) tick();
    nc0 = ncmpl;
    rst = 1'b1;
    en = 1'b0;
    tick();
    check_reset_outputs("midreset");
    model_reset();
    rst = 1'b0;
    wait_ncmpl(nc0 + 1, 60);
    repeat (3) tick();
    for (int i = 0; i < 6; i++)
      chk($sformatf("late_cmplt_pot%0d", i),
          32'(pot_of(i)), 32'(ref_pot[i]));
    rst_test = 1'b0;

    // HP gets 0x400 then 0x800 across two scans
    for (int i = 0; i < 11; i++) begin
      p.lat = $urandom_range(20, 4);
      p.val = (i == 4) ? 12'h400 :
              (i == 10) ? 12'h800 : 12'($urandom);
      plan_q.push_back(p);
    end
    nc0 = ncmpl;
    n0 = nreq;
    raise_en();
    wait_nreq(n0 + 11, 11 * (GAP + 30) + 100);
    en = 1'b0;
    wait_ncmpl(nc0 + 11, 100);
    repeat (GAP + 10) tick();
`ifdef POT_FILTER_EN
    chk("pot_hp_smoothed", 32'(pot_hp), 32'h500);
`else
    chk("pot_hp_direct", 32'(pot_hp), 32'h800);
`endif
    chk("final_timeout_err", 32'(timeout_err), 32'(ref_err));
    chk("pending_requests", exp_req.size(), 0);
    chk("pending_scan_done", exp_done.size(), 0);
    chk("pending_pot_checks", exp_pot.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
